// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 16x oversampling and byte storage
//
// Purpose:
//   Receives 8N1 serial frames on rxd. Each bit is decided by a 3-sample
//   majority taken around mid-bit. Good bytes are stored for the host to read.
//
// Ports:
//   clk24     - system clock, all logic on its rising edge
//   mreset    - synchronous active-high reset
//   rxd       - asynchronous serial input, idle high
//   rd        - one-clock pop strobe for the head byte (ignored while rdy=0)
//   data      - registered head byte, meaningful while rdy=1
//   rdy       - at least one received byte is available
//   frame_err - one-clock pulse when a stop bit is sampled low
//   overrun   - sticky, set when a byte is dropped because storage is full
//   busy      - receiver FSM is outside IDLE
//
// Build option:
//   UART_RX_FIFO_EN - when defined, storage is a 4-entry FIFO; otherwise
//                     it is a single holding register.

module uart_rx #(
  parameter int CLK_HZ = 24000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk24,
  input  logic       mreset,
  input  logic       rxd,
  input  logic       rd,
  output logic [7:0] data,
  output logic       rdy,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  // Rounded clocks-per-oversample-tick.
  localparam int DIV   = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    WAITHI = 3'd4
  } state_t;

  state_t state, state_next;

  logic             rx_meta;
  logic             rx_sync;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [3:0]       tick_cnt;
  logic [1:0]       samp;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             maj;
  logic             mid_eval;
  logic             bit_take;
  logic             push;
  logic             frame_pulse;
  logic             pop;
  logic             full;
  logic             accept;

  // Two-flop synchronizer; both flops reset to the idle line level.
  always_ff @(posedge clk24) begin
    if (mreset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_sync <= rx_meta;
    end
  end

  // Oversample tick generator. Held at zero in IDLE so that counting
  // restarts exactly on the IDLE->START transition.
  always_ff @(posedge clk24) begin
    if (mreset) begin
      div_cnt <= '0;
    end else if (state == IDLE) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign tick = (state != IDLE) && (div_cnt == DIV_LAST);

  // Tick position inside the current 16-tick bit window. tick_cnt holds the
  // number of ticks already seen, so the tick occurring while tick_cnt==N is
  // tick N+1 of the window. It wraps naturally from one window to the next.
  always_ff @(posedge clk24) begin
    if (mreset) begin
      tick_cnt <= 4'd0;
    end else if (state == IDLE) begin
      tick_cnt <= 4'd0;
    end else if (tick) begin
      tick_cnt <= tick_cnt + 4'd1;
    end
  end

  // Capture ticks 7 and 8; tick 9 is taken live from rx_sync at evaluation.
  always_ff @(posedge clk24) begin
    if (mreset) begin
      samp <= 2'b00;
    end else if (tick && (tick_cnt == 4'd6)) begin
      samp[0] <= rx_sync;
    end else if (tick && (tick_cnt == 4'd7)) begin
      samp[1] <= rx_sync;
    end
  end

  assign mid_eval = tick && (tick_cnt == 4'd8);
  assign maj      = (samp[0] & samp[1]) | (samp[0] & rx_sync) | (samp[1] & rx_sync);

  // Bit counter and LSB-first shift register.
  always_ff @(posedge clk24) begin
    if (mreset) begin
      bit_cnt <= 3'd0;
      shift   <= 8'h00;
    end else begin
      if (state == IDLE) begin
        bit_cnt <= 3'd0;
      end else if (bit_take) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (bit_take) begin
        shift <= {maj, shift[7:1]};
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk24) begin
    if (mreset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state and strobes.
  always_comb begin
    state_next  = state;
    bit_take    = 1'b0;
    push        = 1'b0;
    frame_pulse = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_sync) begin
          state_next = START;
        end
      end
      START: begin
        if (mid_eval) begin
          state_next = maj ? IDLE : DATA;
        end
      end
      DATA: begin
        if (mid_eval) begin
          bit_take = 1'b1;
          // Last bit when the counter is about to wrap 7->0.
          if (bit_cnt == 3'd7) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (mid_eval) begin
          if (maj) begin
            push       = 1'b1;
            state_next = IDLE;
          end else begin
            frame_pulse = 1'b1;
            state_next  = WAITHI;
          end
        end
      end
      WAITHI: begin
        // A held-low break stays here, so it reports only one frame error.
        if (rx_sync) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk24) begin
    if (mreset) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= frame_pulse;
    end
  end

  assign busy = (state != IDLE);

  // Storage handshake shared by both builds. A pop in the same clock frees a
  // slot, so a push into full storage is still accepted.
  assign pop    = rd && rdy;
  assign accept = push && (!full || pop);

  always_ff @(posedge clk24) begin
    if (mreset) begin
      overrun <= 1'b0;
    end else if (push && full && !pop) begin
      overrun <= 1'b1;
    end
  end

`ifdef UART_RX_FIFO_EN

  logic [7:0] mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [1:0] rd_ptr_inc;
  logic [2:0] count;
  logic [7:0] head_next;

  assign full       = (count == 3'd4);
  assign rdy        = (count != 3'd0);
  assign rd_ptr_inc = rd_ptr + 2'd1;

  // When full, wr_ptr equals rd_ptr; a simultaneous pop+push overwrites the
  // slot that is being popped, which is safe.
  always_ff @(posedge clk24) begin
    if (accept) begin
      mem[wr_ptr] <= shift;
    end
  end

  always_ff @(posedge clk24) begin
    if (mreset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr_inc;
      end
      case ({accept, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Registered head: after a pop it is the next stored entry (or the byte
  // arriving this clock if nothing else remains); a push into empty storage
  // makes the new byte the head.
  always_comb begin
    head_next = data;
    if (pop) begin
      if (count >= 3'd2) begin
        head_next = mem[rd_ptr_inc];
      end else if (accept) begin
        head_next = shift;
      end
    end else if (accept && (count == 3'd0)) begin
      head_next = shift;
    end
  end

  always_ff @(posedge clk24) begin
    if (mreset) begin
      data <= 8'h00;
    end else begin
      data <= head_next;
    end
  end

`else

  logic hold_valid;

  assign full = hold_valid;
  assign rdy  = hold_valid;

  // Single holding register; data doubles as the storage element.
  always_ff @(posedge clk24) begin
    if (mreset) begin
      hold_valid <= 1'b0;
      data       <= 8'h00;
    end else if (accept) begin
      hold_valid <= 1'b1;
      data       <= shift;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

`endif

endmodule
